// File: rtl/hazard_stall_controller_if.sv
// Hazard/stall controller bus.
// Groups the pipeline-side hazard inputs and the controller's stall/flush/
// statistics outputs into one bundle.
//   master : pipeline side; drives the ID/EX hazard inputs and observes the controls
//   slave  : controller side; observes the hazard inputs and drives the controls
// Hazard inputs: rs1D, rs2D, rdE, memReadE, pcSrcE, mcStartE
// Controls     : stallF, stallD, stallE, flushD, flushE, bubbleM, mcDoneE, mcBusy
// Statistics   : stallCount (CNT_W bits, saturating)
interface hazard_stall_controller_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       rs1D;
    logic [4:0]       rs2D;
    logic [4:0]       rdE;
    logic             memReadE;
    logic             pcSrcE;
    logic             mcStartE;
    logic             stallF;
    logic             stallD;
    logic             stallE;
    logic             flushD;
    logic             flushE;
    logic             bubbleM;
    logic             mcDoneE;
    logic             mcBusy;
    logic [CNT_W-1:0] stallCount;

    modport master (
        output rs1D, rs2D, rdE, memReadE, pcSrcE, mcStartE,
        input  stallF, stallD, stallE, flushD, flushE, bubbleM, mcDoneE, mcBusy, stallCount
    );

    modport slave (
        input  rs1D, rs2D, rdE, memReadE, pcSrcE, mcStartE,
        output stallF, stallD, stallE, flushD, flushE, bubbleM, mcDoneE, mcBusy, stallCount
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller for hazards that EX forwarding cannot resolve:
// load-use (one bubble), taken branch/jump (flush ID and EX) and multi-cycle EX
// ops that hold the front of the pipe for MC_LATENCY cycles. Also counts the
// cycles in which the PC was held.
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : synchronous reset, active-high; forces every control output to 0
//   bus  : slave side of hazard_stall_controller_if (hazard inputs in,
//          stall/flush/bubble/done/busy controls and stallCount out)
module hazard_stall_controller #(
    parameter int MC_LATENCY = 8,
    parameter int CNT_W      = 32
) (
    input logic                   clk,
    input logic                   rst,
    hazard_stall_controller_if.slave bus
);
    localparam int MCW = $clog2(MC_LATENCY + 1);

    typedef enum logic {
        RUN,
        MC_BUSY
    } state_t;

    state_t           state;
    logic [MCW-1:0]   mc_cnt;
    logic [CNT_W-1:0] stall_count;

    logic load_use;
    logic stall_f, stall_d, stall_e;
    logic flush_d, flush_e, bubble_m;
    logic mc_done, mc_busy;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // x0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign load_use = bus.memReadE && (bus.rdE != 5'd0) &&
                      ((bus.rdE == bus.rs1D) || (bus.rdE == bus.rs2D));

    always_comb begin
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        stall_e  = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        bubble_m = 1'b0;
        mc_done  = 1'b0;
        mc_busy  = 1'b0;
        if (!rst) begin
            case (state)
                RUN: begin
                    // Branch redirect wins: the EX op is on the wrong path anyway.
                    if (bus.pcSrcE) begin
                        flush_d = 1'b1;
                        flush_e = 1'b1;
                    end else if (bus.mcStartE) begin
                        stall_f  = 1'b1;
                        stall_d  = 1'b1;
                        stall_e  = 1'b1;
                        bubble_m = 1'b1;
                    end else if (load_use) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        flush_e = 1'b1;
                    end
                end
                MC_BUSY: begin
                    mc_busy = 1'b1;
                    if (mc_cnt > MCW'(1)) begin
                        stall_f  = 1'b1;
                        stall_d  = 1'b1;
                        stall_e  = 1'b1;
                        bubble_m = 1'b1;
                    end else begin
                        // Last EX cycle: result is valid and advances to MEM.
                        mc_done = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            mc_cnt      <= '0;
            stall_count <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (!bus.pcSrcE && bus.mcStartE) begin
                        state  <= MC_BUSY;
                        mc_cnt <= MCW'(MC_LATENCY - 1);
                    end
                end
                MC_BUSY: begin
                    if (mc_cnt > MCW'(1)) begin
                        mc_cnt <= mc_cnt - MCW'(1);
                    end else begin
                        state  <= RUN;
                        mc_cnt <= '0;
                    end
                end
                default: begin
                    state  <= RUN;
                    mc_cnt <= '0;
                end
            endcase
            if (stall_f) begin
                stall_count <= sat_inc(stall_count);
            end
        end
    end

    assign bus.stallF     = stall_f;
    assign bus.stallD     = stall_d;
    assign bus.stallE     = stall_e;
    assign bus.flushD     = flush_d;
    assign bus.flushE     = flush_e;
    assign bus.bubbleM    = bubble_m;
    assign bus.mcDoneE    = mc_done;
    assign bus.mcBusy     = mc_busy;
    assign bus.stallCount = stall_count;
endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller. Two instances share one
// stimulus stream: MC_LATENCY=8/CNT_W=32 and MC_LATENCY=2/CNT_W=4.
module tb_hazard_stall_controller;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] rs1D, rs2D, rdE;
    logic       memReadE, pcSrcE, mcStartE;

    hazard_stall_controller_if #(.CNT_W(32)) bus_m ();
    hazard_stall_controller_if #(.CNT_W(4))  bus_s ();

    assign bus_m.rs1D = rs1D;  assign bus_s.rs1D = rs1D;
    assign bus_m.rs2D = rs2D;  assign bus_s.rs2D = rs2D;
    assign bus_m.rdE  = rdE;   assign bus_s.rdE  = rdE;
    assign bus_m.memReadE = memReadE;  assign bus_s.memReadE = memReadE;
    assign bus_m.pcSrcE   = pcSrcE;    assign bus_s.pcSrcE   = pcSrcE;
    assign bus_m.mcStartE = mcStartE;  assign bus_s.mcStartE = mcStartE;

    hazard_stall_controller #(.MC_LATENCY(8), .CNT_W(32)) dut_m (
        .clk(clk), .rst(rst), .bus(bus_m.slave));
    hazard_stall_controller #(.MC_LATENCY(2), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .bus(bus_s.slave));

    int n_cmp = 0;
    int n_bad = 0;

    // Output vector order: {stallF, stallD, stallE, flushD, flushE, bubbleM, mcDoneE, mcBusy}
    localparam logic [7:0] O_NONE   = 8'b0000_0000;
    localparam logic [7:0] O_LU     = 8'b1100_1000;
    localparam logic [7:0] O_BR     = 8'b0001_1000;
    localparam logic [7:0] O_MCST   = 8'b1110_0100;
    localparam logic [7:0] O_MCBUSY = 8'b1110_0101;
    localparam logic [7:0] O_MCDONE = 8'b0000_0011;

    // Reference model: an op started at cycle S occupies EX cycles S..S+L-1,
    // holds the front end until S+L-2 and reports done at S+L-1.
    int          lat [2] = '{8, 2};
    longint      cmax[2] = '{64'h0000_0000_FFFF_FFFF, 64'd15};
    bit          in_op[2];
    longint      start_cyc[2];
    longint      mcnt[2];
    longint      cyc = 0;
    logic [7:0]  exp_o[2];
    logic [7:0]  obs[2];
    logic [63:0] ocnt[2];

    function automatic logic [7:0] model_out(int k);
        bit lu;
        lu = memReadE && (rdE != 0) && (rdE == rs1D || rdE == rs2D);
        if (rst) return O_NONE;
        if (in_op[k]) return (cyc < start_cyc[k] + lat[k] - 1) ? O_MCBUSY : O_MCDONE;
        if (pcSrcE) return O_BR;
        if (mcStartE) return O_MCST;
        if (lu) return O_LU;
        return O_NONE;
    endfunction

    task automatic model_update(int k);
        if (rst) begin
            in_op[k] = 1'b0;
            mcnt[k]  = 0;
        end else begin
            if (exp_o[k][7] && mcnt[k] < cmax[k]) mcnt[k]++;
            if (in_op[k] && cyc == start_cyc[k] + lat[k] - 1) begin
                in_op[k] = 1'b0;
            end else if (!in_op[k] && !pcSrcE && mcStartE) begin
                in_op[k]     = 1'b1;
                start_cyc[k] = cyc;
            end
        end
    endtask

    task automatic chk(string name, logic [63:0] got, logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
        end
    endtask

    // One clock: observe at the falling edge, check against the model, then
    // advance the model with the inputs the DUT samples at the rising edge.
    task automatic tick();
        @(negedge clk);
        obs[0]  = {bus_m.stallF, bus_m.stallD, bus_m.stallE, bus_m.flushD,
                   bus_m.flushE, bus_m.bubbleM, bus_m.mcDoneE, bus_m.mcBusy};
        obs[1]  = {bus_s.stallF, bus_s.stallD, bus_s.stallE, bus_s.flushD,
                   bus_s.flushE, bus_s.bubbleM, bus_s.mcDoneE, bus_s.mcBusy};
        ocnt[0] = 64'(bus_m.stallCount);
        ocnt[1] = 64'(bus_s.stallCount);
        for (int k = 0; k < 2; k++) begin
            exp_o[k] = model_out(k);
            chk(k == 0 ? "model_out_L8" : "model_out_L2", 64'(obs[k]), 64'(exp_o[k]));
            chk(k == 0 ? "model_cnt_L8" : "model_cnt_L2", ocnt[k], 64'(mcnt[k]));
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_update(k);
        cyc++;
        #1;
    endtask

    task automatic set_in(logic r, logic [4:0] a, logic [4:0] b, logic [4:0] d,
                          logic mr, logic pc, logic mc);
        rst = r; rs1D = a; rs2D = b; rdE = d; memReadE = mr; pcSrcE = pc; mcStartE = mc;
    endtask

    typedef struct {
        logic       r;
        logic [4:0] a, b, d;
        logic       mr, pc, mc;
        logic [7:0] exp;
        int         exp_cnt;
    } vec_t;

    vec_t tbl[11];
    logic [7:0] seq_m[12];
    logic [7:0] seq_s[12];
    logic [63:0] base_m, base_s;

    initial begin
        tbl[0]  = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, O_NONE, 0};
        tbl[1]  = '{1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, O_NONE, 0};
        tbl[2]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, O_NONE, 0};
        tbl[3]  = '{1'b0, 5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, O_LU,   0};
        tbl[4]  = '{1'b0, 5'd0, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, O_NONE, 1};
        tbl[5]  = '{1'b0, 5'd7, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, O_LU,   1};
        tbl[6]  = '{1'b0, 5'd7, 5'd2, 5'd7, 1'b0, 1'b0, 1'b0, O_NONE, 2};
        tbl[7]  = '{1'b0, 5'd3, 5'd4, 5'd7, 1'b1, 1'b0, 1'b0, O_NONE, 2};
        tbl[8]  = '{1'b0, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, O_BR,   2};
        tbl[9]  = '{1'b0, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b1, O_BR,   2};
        tbl[10] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, O_NONE, 2};

        // Bring state out of X before anything is compared.
        set_in(1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_update(k);
        cyc++;
        #1;

        // Table: reset behaviour, load-use, x0, branch priority.
        for (int i = 0; i < 11; i++) begin
            set_in(tbl[i].r, tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].mr, tbl[i].pc, tbl[i].mc);
            tick();
            chk($sformatf("tbl_out[%0d]", i), 64'(obs[0]), 64'(tbl[i].exp));
            chk($sformatf("tbl_cnt[%0d]", i), ocnt[0], 64'(tbl[i].exp_cnt));
        end

        // Single multi-cycle op, pulsed start.
        set_in(1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0); tick();
        rst = 1'b0; mcStartE = 1'b1;
        tick();
        seq_m[0] = obs[0]; seq_s[0] = obs[1]; base_m = ocnt[0]; base_s = ocnt[1];
        mcStartE = 1'b0;
        for (int i = 1; i < 9; i++) begin
            tick();
            seq_m[i] = obs[0]; seq_s[i] = obs[1];
        end
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("mc8_seq[%0d]", i), 64'(seq_m[i]),
                64'(i == 0 ? O_MCST : i < 7 ? O_MCBUSY : i == 7 ? O_MCDONE : O_NONE));
            chk($sformatf("mc2_seq[%0d]", i), 64'(seq_s[i]),
                64'(i == 0 ? O_MCST : i == 1 ? O_MCDONE : O_NONE));
        end
        chk("mc8_cnt_delta", ocnt[0] - base_m, 64'd7);
        chk("mc2_cnt_delta", ocnt[1] - base_s, 64'd1);

        // Reset in the middle of a multi-cycle op.
        set_in(1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0); tick();
        rst = 1'b0; mcStartE = 1'b1; tick();
        mcStartE = 1'b0; tick(); tick();
        rst = 1'b1; tick();
        chk("rst_mid_op_out", 64'(obs[0]), 64'(O_NONE));
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("post_rst_idle[%0d]", i), 64'(obs[0]), 64'(O_NONE));
        end
        chk("post_rst_cnt", ocnt[0], 64'd0);

        // Saturation: 20 consecutive load-use cycles.
        set_in(1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0); tick();
        set_in(1'b0, 5'd9, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        set_in(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0); tick();
        chk("sat_cnt_L8", ocnt[0], 64'd20);
        chk("sat_cnt_L2", ocnt[1], 64'd15);

        // Back-to-back ops with mcStartE held high throughout.
        set_in(1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0); tick();
        rst = 1'b0; mcStartE = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            seq_m[i] = obs[0]; seq_s[i] = obs[1];
        end
        mcStartE = 1'b0;
        chk("b2b_L8_done",    64'(seq_m[7]), 64'(O_MCDONE));
        chk("b2b_L8_restart", 64'(seq_m[8]), 64'(O_MCST));
        chk("b2b_L8_busy2",   64'(seq_m[9]), 64'(O_MCBUSY));
        chk("b2b_L2_done",    64'(seq_s[1]), 64'(O_MCDONE));
        chk("b2b_L2_restart", 64'(seq_s[2]), 64'(O_MCST));
        chk("b2b_L2_done2",   64'(seq_s[3]), 64'(O_MCDONE));

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            set_in(($urandom_range(0, 99) == 0),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)),
                   ($urandom_range(0, 2) == 0),
                   ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 5) == 0));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
